// File: rtl/alu_pkg.sv
// Shared types and instruction field layout for the ALU issue/writeback sequencer.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_EOR = 3'b100,
        OP_BIC = 3'b101,
        OP_RSB = 3'b110,
        OP_BEQ = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } seq_state_t;

    localparam int INSTR_W = 16;
    localparam int RIDX_W  = 2;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int IMM_BIT = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 10;
    localparam int RN_HI   = 9;
    localparam int RN_LO   = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;
    localparam int RM_HI   = 1;
    localparam int RM_LO   = 0;

    typedef struct packed {
        alu_op_t           op;
        logic              imm;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] rn;
        logic [RIDX_W-1:0] rm;
        logic [7:0]        imm8;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.op   = alu_op_t'(w[OP_HI:OP_LO]);
        d.imm  = w[IMM_BIT];
        d.rd   = w[RD_HI:RD_LO];
        d.rn   = w[RN_HI:RN_LO];
        d.rm   = w[RM_HI:RM_LO];
        d.imm8 = w[IMM_HI:IMM_LO];
        return d;
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Small register file: one write port, three combinational read ports, async clear.
module regfile_4x8 #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     rn_addr,
    output logic [DATA_W-1:0] rn_data,
    input  logic [AW-1:0]     rm_addr,
    output logic [DATA_W-1:0] rm_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rn_data  = mem_q[rn_addr];
    assign rm_data  = mem_q[rm_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_exec_sequencer.sv
// Four-state issue/writeback controller feeding an external 8-bit ALU.
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_ctrl,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_eq,
    output logic               done,
    output logic               branch_taken,
    output logic [7:0]         branch_off,
    input  logic [RIDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    seq_state_t         state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    alu_op_t            alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               done_q, done_d;
    logic               branch_taken_q, branch_taken_d;
    logic [7:0]         branch_off_q, branch_off_d;

    instr_t             dec;
    logic               rf_we;
    logic [DATA_W-1:0]  rn_data, rm_data;

    assign dec = decode_instr(ir_q);

    regfile_4x8 #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (dec.rd),
        .wdata    (result_q),
        .rn_addr  (dec.rn),
        .rn_data  (rn_data),
        .rm_addr  (dec.rm),
        .rm_data  (rm_data),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_ctrl_d     = alu_ctrl_q;
        result_d       = result_q;
        done_d         = 1'b0;
        branch_taken_d = 1'b0;
        branch_off_d   = branch_off_q;
        rf_we          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_a_d    = rn_data;
                alu_b_d    = dec.imm ? DATA_W'(dec.imm8) : rm_data;
                alu_ctrl_d = dec.op;
                state_d    = S_EXECUTE;
            end
            S_EXECUTE: begin
                // done/branch_taken are flopped here so they are high during WRITEBACK;
                // alu_eq is meaningless unless the ALU is doing BEQ.
                result_d       = alu_out;
                done_d         = 1'b1;
                branch_taken_d = (dec.op == OP_BEQ) && alu_eq;
                if (dec.op == OP_BEQ) branch_off_d = dec.imm8;
                state_d        = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                rf_we   = (dec.op != OP_BEQ);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ir_q           <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= OP_ADD;
            result_q       <= '0;
            done_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            branch_off_q   <= '0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_ctrl_q     <= alu_ctrl_d;
            result_q       <= result_d;
            done_q         <= done_d;
            branch_taken_q <= branch_taken_d;
            branch_off_q   <= branch_off_d;
        end
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign done         = done_q;
    assign branch_taken = branch_taken_q;
    assign branch_off   = branch_off_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Scoreboard bench: reference register model plus behavioural ALU beside the sequencer.
module tb_alu_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_ctrl;
    logic        alu_eq;
    logic        done, branch_taken;
    logic [7:0]  branch_off;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        int         cyc;
        logic       taken;
        logic [7:0] off;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mreg [4];

    alu_exec_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_out      (alu_out),
        .alu_eq       (alu_eq),
        .done         (done),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a & ~b;
            3'd6: return b - a;
            default: return a - b;
        endcase
    endfunction

    // Equality is driven for every op so the sequencer's BEQ-only sampling matters.
    always_comb begin
        alu_out = model_alu(alu_ctrl, alu_a, alu_b);
        alu_eq  = (alu_a == alu_b);
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic imm, input logic [1:0] rd,
                                        input logic [1:0] rn, input logic [7:0] low8);
        return {op, imm, rd, rn, low8};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no retire", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc || branch_taken !== e.taken || (e.taken && branch_off !== e.off)) begin
                    errors++;
                    $display("FAIL retire: got cyc=%0d taken=%0b off=%02h, required cyc=%0d taken=%0b off=%02h",
                             cyc, branch_taken, branch_off, e.cyc, e.taken, e.off);
                end
            end
        end else if (!rst && branch_taken) begin
            checks++;
            errors++;
            $display("FAIL branch_without_done: got branch_taken=1 done=0, required branch_taken=0");
        end
    end

    // Called at #1 after a rising edge with instr_ready already seen high.
    task automatic push_expect(input logic [15:0] w);
        exp_t e;
        logic [7:0] a, b, r;
        a = mreg[w[9:8]];
        b = w[12] ? w[7:0] : mreg[w[1:0]];
        r = model_alu(w[15:13], a, b);
        e.cyc   = cyc + 3;
        e.taken = (w[15:13] == 3'd7) && (a == b);
        e.off   = w[7:0];
        if (w[15:13] != 3'd7) mreg[w[11:10]] = r;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(posedge clk); #1;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got instr_ready=0, required 1 within 20 cycles", tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_retire_timeout: got %0d pending, required 0", tag, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [15:0] w);
        wait_ready("issue");
        instr       = w;
        instr_valid = 1'b1;
        push_expect(w);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_idle("issue");
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            checks++;
            if (dbg_data !== mreg[r]) begin
                errors++;
                $display("FAIL %s_r%0d: got %02h, required %02h", tag, r, dbg_data, mreg[r]);
            end
        end
    endtask

    task automatic test_reset();
        for (int r = 0; r < 4; r++) mreg[r] = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || branch_taken !== 1'b0 || branch_off !== 8'h00 ||
            alu_a !== 8'h00 || alu_b !== 8'h00 || alu_ctrl !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%0b done=%0b bt=%0b off=%02h a=%02h b=%02h ctrl=%0d, required 1 0 0 00 00 00 0",
                     instr_ready, done, branch_taken, branch_off, alu_a, alu_b, alu_ctrl);
        end
        check_regs("reset");
    endtask

    task automatic test_add_imm();
        issue(16'h1005);
        dbg_sel = 2'd0;
        #1;
        checks++;
        if (dbg_data !== 8'h05) begin
            errors++;
            $display("FAIL add_imm_r0: got %02h, required 05", dbg_data);
        end
        check_regs("add_imm");
    endtask

    task automatic test_add_reg_wrap();
        issue(enc(3'd0, 1'b1, 2'd1, 2'd1, 8'd250));
        issue(enc(3'd0, 1'b0, 2'd2, 2'd1, 8'h00));
        dbg_sel = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 8'hFF) begin
            errors++;
            $display("FAIL add_reg_r2: got %02h, required ff", dbg_data);
        end
        issue(enc(3'd0, 1'b1, 2'd2, 2'd2, 8'd1));
        dbg_sel = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 8'h00) begin
            errors++;
            $display("FAIL add_wrap_r2: got %02h, required 00", dbg_data);
        end
        check_regs("add_reg");
    endtask

    task automatic test_rsb_bic();
        issue(enc(3'd6, 1'b1, 2'd3, 2'd0, 8'd3));
        dbg_sel = 2'd3;
        #1;
        checks++;
        if (dbg_data !== 8'hFE) begin
            errors++;
            $display("FAIL rsb_r3: got %02h, required fe", dbg_data);
        end
        issue(enc(3'd5, 1'b1, 2'd3, 2'd3, 8'h0F));
        dbg_sel = 2'd3;
        #1;
        checks++;
        if (dbg_data !== 8'hF0) begin
            errors++;
            $display("FAIL bic_r3: got %02h, required f0", dbg_data);
        end
        check_regs("rsb_bic");
    endtask

    task automatic test_beq();
        issue(enc(3'd7, 1'b1, 2'd0, 2'd0, 8'd5));
        check_regs("beq_taken");
        issue(enc(3'd7, 1'b1, 2'd0, 2'd0, 8'd6));
        check_regs("beq_not_taken");
        checks++;
        if (alu_ctrl !== 3'b111 || alu_a !== 8'h05 || alu_b !== 8'h06) begin
            errors++;
            $display("FAIL alu_hold: got ctrl=%0d a=%02h b=%02h, required 7 05 06", alu_ctrl, alu_a, alu_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        int start_done;
        prog[0] = enc(3'd1, 1'b0, 2'd1, 2'd1, 8'h00);
        prog[1] = enc(3'd4, 1'b1, 2'd3, 2'd0, 8'hAA);
        prog[2] = enc(3'd7, 1'b0, 2'd0, 2'd1, 8'h01);
        start_done = done_cnt;
        wait_ready("b2b");
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = prog[i];
            push_expect(prog[i]);
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                checks++;
                if (instr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy_ready: got 1 at instr %0d step %0d, required 0", i, c);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_idle_ready: got 0 after instr %0d, required 1", i);
            end
        end
        instr_valid = 1'b0;
        wait_idle("b2b");
        checks++;
        if (done_cnt - start_done !== 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d, required 3", done_cnt - start_done);
        end
        check_regs("b2b");
    endtask

    task automatic test_reset_mid_instr();
        wait_ready("midrst");
        instr       = enc(3'd0, 1'b1, 2'd0, 2'd0, 8'd7);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int r = 0; r < 4; r++) mreg[r] = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %0b, required 1", instr_ready);
        end
        repeat (5) @(posedge clk);
        #1;
        dbg_sel = 2'd0;
        #1;
        checks++;
        if (dbg_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_r0: got %02h, required 00", dbg_data);
        end
        check_regs("midrst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_imm();
        test_add_reg_wrap();
        test_rsb_bic();
        test_beq();
        test_back_to_back();
        test_reset_mid_instr();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_sequencer.md
# alu_exec_sequencer

Multi-cycle issue/writeback controller directly upstream of the 8-bit ALU. Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it. Reads operands from an internal 4×8 register file and drives the ALU operand/opcode inputs. Captures the ALU result or equality flag and writes back, or signals a branch.

## Interface
- DATA_W, 8, operand/register width (ALU is fixed at 8)
- NREGS, 4, register-file depth (2-bit register index)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr  in  16  instruction word: [15:13] op, [12] imm flag, [11:10] rd, [9:8] rn, [7:0] imm8 (rm = [1:0] when imm flag = 0)
- instr_valid  in  1  instr is presented
- instr_ready  out  1  sequencer can accept an instruction
- alu_a  out  8  ALU operand A (= R[rn])
- alu_b  out  8  ALU operand B (= imm8 or R[rm])
- alu_ctrl  out  3  ALU opcode (= op, passed through unchanged)
- alu_out  in  8  ALU result
- alu_eq  in  1  ALU equality flag
- done  out  1  one-cycle pulse: instruction retired
- branch_taken  out  1  one-cycle pulse with done: BEQ and operands equal
- branch_off  out  8  imm8 of the retiring BEQ; valid while branch_taken = 1
- dbg_sel  in  2  register-file debug read index
- dbg_data  out  8  R[dbg_sel], combinational

## Operation
- Opcodes match the ALU encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 BIC, 110 RSB, 111 BEQ.
- FSM: IDLE → DECODE → EXECUTE → WRITEBACK → IDLE. No other states. The IDLE→DECODE transition happens only on handshake.
- IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr into ir and go to DECODE.
- DECODE: register alu_a ← R[rn], alu_b ← imm flag ? imm8 : R[rm], alu_ctrl ← op.
- EXECUTE: ALU settles combinationally. Capture result ← alu_out and eq ← alu_eq. Sample alu_eq only when op = 111. For other ops eq ← 0, because the ALU does not drive equality outside BEQ.
- WRITEBACK: for op ≠ 111, R[rd] ← result. For op = 111, no register write and branch_taken = eq. Assert done. Return to IDLE.
- Arithmetic wraps modulo 256 inside the ALU. The sequencer performs no extension or saturation.
- rd may equal rn or rm. The operands were registered in DECODE, so the old value is used.
- alu_a, alu_b and alu_ctrl hold their last values outside DECODE and are not cleared on retire.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state = IDLE
  - all R[i] = 0
  - ir = 0
  - alu_a = alu_b = 0
  - alu_ctrl = 000
  - done = branch_taken = 0
  - branch_off = 0
  - instr_ready = 1 in the first cycle after reset
- Latency: handshake at edge N, then DECODE in cycle N+1, EXECUTE in N+2, WRITEBACK in N+3. done is high during cycle N+3. The register write is visible on dbg_data from cycle N+4.
- Throughput: one instruction per 4 cycles. instr_ready is low in DECODE, EXECUTE and WRITEBACK. instr_valid in those states is ignored, not queued.
- instr_ready depends only on state, never combinationally on instr_valid.
- Reset mid-instruction aborts it: no writeback, no done, registers cleared.
- done and branch_taken are registered and last exactly one cycle.

## Structure
- Package alu_pkg holds:
  - alu_op_t, a 3-bit enum with the eight opcodes above
  - the seq_state_t enum
  - instruction field position constants
- Sub-module regfile_4x8 provides 1 write port, 3 combinational read ports (rn, rm, dbg) and async reset to zero.
- The ALU is instantiated beside this block at top level, not inside it.

## Test plan
- Reset, then ADD imm r0 = r0 + 5 (instr 0x1005) → done at cycle 3 after handshake; dbg_sel = 0 gives 0x05.
- r0 = 5, r1 = 250, then ADD reg r2 = r1 + r0 → r2 = 0xFF. Then ADD imm r2 = r2 + 1 → r2 = 0x00 (wrap).
- r0 = 5: RSB imm r3 = 3 − r0 → r3 = 0xFE. BIC imm r3 = r3 & ~0x0F → r3 = 0xF0.
- r0 = 5: BEQ imm rn = r0, imm8 = 5 → branch_taken = 1 with done, branch_off = 0x05, no register changes. Then BEQ with imm8 = 6 → branch_taken = 0, done = 1.
- Hold instr_valid high continuously with 3 back-to-back instructions → instr_ready high only in IDLE, exactly 3 done pulses spaced 4 cycles apart.
- Assert rst during EXECUTE of ADD r0 = r0 + 7 → no done pulse, r0 reads 0, instr_ready = 1 in the cycle after rst deasserts.
